// File: rtl/tag_fifo_pkg.sv
// ----------------------------------------------------------------------------
// tag_fifo_pkg
// Shared definitions for the rename tag free list. The register status table
// and the reservation stations import this package too, so the tag width and
// the tag type stay the same across the core.
//   TAG_W   : width of one physical tag
//   TAG_NUM : number of tags in circulation
//   PTR_W   : free-list pointer width (index bits plus one wrap bit)
// ----------------------------------------------------------------------------
package tag_fifo_pkg;

   localparam int TAG_W   = 6;
   localparam int TAG_NUM = 64;
   localparam int PTR_W   = 7;

   typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/tag_fifo.sv
// ----------------------------------------------------------------------------
// tag_fifo
// Circular free list of rename tags. After reset it holds every tag 0..63 in
// ascending order. Dispatch pops free tags from the head, and commit pushes
// retired tags back at the tail.
//
// Ports
//   clk                 : single clock, rising edge
//   reset               : asynchronous, active-high reset
//   dispatch_tag_ren    : pop one free tag this cycle
//   dispatch_tag        : head-of-list tag (show-ahead, combinational)
//   dispatch_tag_empty  : no free tag available
//   commit_tag_wen      : push one retired tag this cycle
//   commit_tag          : tag being returned
//   tag_fifo_full       : all 64 tags are free
//   tag_fifo_count      : number of free tags, 0..64
//   tag_fifo_err        : sticky protocol-error flag
//
// Configuration macro
//   TAG_FIFO_ERR_EN : when defined, tag_fifo_err latches any ignored pop or
//                     ignored push until reset. When undefined, the flag is
//                     tied low and no error logic is built.
// ----------------------------------------------------------------------------
module tag_fifo
   import tag_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              dispatch_tag_ren,
   output logic [TAG_W-1:0]  dispatch_tag,
   output logic              dispatch_tag_empty,
   input  logic              commit_tag_wen,
   input  logic [TAG_W-1:0]  commit_tag,
   output logic              tag_fifo_full,
   output logic [PTR_W-1:0]  tag_fifo_count,
   output logic              tag_fifo_err
);

   tag_t             r_mem [TAG_NUM];
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_count;

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;

   // Empty and full come from the registered pointers only. The wrap bit
   // tells a full list apart from an empty one when the index bits match.
   assign w_empty = (r_rptr == r_wptr);
   assign w_full  = (r_rptr[PTR_W-2:0] == r_wptr[PTR_W-2:0]) &&
                    (r_rptr[PTR_W-1] != r_wptr[PTR_W-1]);

   // A pop is ignored when the list is empty, and a push is ignored when it
   // is full. A push into an empty list is never forwarded to the head in
   // the same cycle.
   assign w_pop  = dispatch_tag_ren && !w_empty;
   assign w_push = commit_tag_wen && !w_full;

   assign dispatch_tag       = r_mem[r_rptr[PTR_W-2:0]];
   assign dispatch_tag_empty = w_empty;
   assign tag_fifo_full      = w_full;
   assign tag_fifo_count     = r_count;

   // The storage is reset as well, so that the list starts with every tag
   // free in identity order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TAG_NUM; i++) begin
            r_mem[i] <= tag_t'(i);
         end
      end else if (w_push) begin
         r_mem[r_wptr[PTR_W-2:0]] <= commit_tag;
      end
   end

   // The pointers wrap naturally at 128. The write pointer starts one full
   // lap ahead of the read pointer, so reset leaves the list full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rptr <= '0;
         r_wptr <= PTR_W'(TAG_NUM);
      end else begin
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
      end
   end

   // The count is kept as its own register, so the output does not depend
   // on a pointer subtraction. It moves only when exactly one side
   // succeeds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= PTR_W'(TAG_NUM);
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef TAG_FIFO_ERR_EN
   logic r_err;
   logic w_errEvent;

   // A pop into an empty list counts as an error only if no push arrives in
   // the same cycle. A push into a full list always counts as an error, even
   // when a pop arrives alongside it.
   assign w_errEvent = (dispatch_tag_ren && w_empty && !commit_tag_wen) ||
                       (commit_tag_wen && w_full);

   // The flag is sticky and clears only on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_errEvent) begin
         r_err <= 1'b1;
      end
   end

   assign tag_fifo_err = r_err;
`else
   assign tag_fifo_err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_fifo.sv
// ----------------------------------------------------------------------------
// tb_tag_fifo
// Bench for tag_fifo. The reference is a queue of free tags. It starts as
// 0..63 on reset, loses its head on an accepted pop and gains commit_tag on
// an accepted push. The outputs are compared with that queue on every
// falling edge. Directed scenarios with literal expectations pin the model
// down, and a randomized phase follows them.
// ----------------------------------------------------------------------------
module tb_tag_fifo;

   logic       clk;
   logic       reset;
   logic       ren;
   logic [5:0] dispatchTag;
   logic       empty;
   logic       wen;
   logic [5:0] commitTag;
   logic       full;
   logic [6:0] count;
   logic       err;

   int testsRun;
   int testsFailed;
   bit compareEn;

`ifdef TAG_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic [5:0] freeQ [$];
   bit         modelErr;
   int         qSize;

   tag_fifo dut (
      .clk                (clk),
      .reset              (reset),
      .dispatch_tag_ren   (ren),
      .dispatch_tag       (dispatchTag),
      .dispatch_tag_empty (empty),
      .commit_tag_wen     (wen),
      .commit_tag         (commitTag),
      .tag_fifo_full      (full),
      .tag_fifo_count     (count),
      .tag_fifo_err       (err)
   );

   // The clock has a period of 10; rising edges fall at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Records one comparison and reports it if it fails.
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drives one cycle of requests, which take effect on the next rising
   // edge. Returns 1 time unit after that edge with the requests withdrawn.
   task automatic applyStimulus(input bit r, input bit w, input logic [5:0] t);
      ren       = r;
      wen       = w;
      commitTag = t;
      @(posedge clk);
      #1;
      ren = 1'b0;
      wen = 1'b0;
   endtask

   // Asserts reset between edges, holds it across one rising edge, and
   // releases it between edges.
   task automatic doReset();
      ren = 1'b0;
      wen = 1'b0;
      #2 reset = 1'b1;
      @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // The reference model works on the free list as a plain queue.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         freeQ.delete();
         for (int i = 0; i < 64; i++) freeQ.push_back(6'(i));
         modelErr = 1'b0;
      end else begin
         qSize = freeQ.size();
         if ((ren && qSize == 0 && !wen) || (wen && qSize == 64)) modelErr = 1'b1;
         if (ren && qSize > 0) void'(freeQ.pop_front());
         if (wen && qSize < 64) freeQ.push_back(commitTag);
      end
   end

   // Compares the DUT outputs with the model on every falling edge.
   always @(negedge clk) begin
      if (compareEn) begin
         checkOutput("cyc_count", int'(count), freeQ.size());
         checkOutput("cyc_empty", int'(empty), int'(freeQ.size() == 0));
         checkOutput("cyc_full", int'(full), int'(freeQ.size() == 64));
         checkOutput("cyc_err", int'(err), int'(ERR_EN && modelErr));
         if (freeQ.size() > 0) checkOutput("cyc_tag", int'(dispatchTag), int'(freeQ[0]));
      end
   end

   int pRen;
   int pWen;

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      compareEn   = 1'b0;
      reset       = 1'b0;
      ren         = 1'b0;
      wen         = 1'b0;
      commitTag   = '0;
      #1 reset = 1'b1;
      #12 reset = 1'b0;
      @(posedge clk);
      #1;
      compareEn = 1'b1;

      // State right after reset.
      checkOutput("rst_count", int'(count), 64);
      checkOutput("rst_tag", int'(dispatchTag), 0);
      checkOutput("rst_full", int'(full), 1);
      checkOutput("rst_empty", int'(empty), 0);
      checkOutput("rst_err", int'(err), 0);

      // Drain all 64 tags; they must come out in identity order.
      for (int i = 0; i < 64; i++) begin
         checkOutput("drain_tag", int'(dispatchTag), i);
         checkOutput("drain_count", int'(count), 64 - i);
         applyStimulus(1'b1, 1'b0, 6'd0);
      end
      checkOutput("drain_empty", int'(empty), 1);
      checkOutput("drain_count0", int'(count), 0);

      // Push and pop together while empty: the push wins and there is no
      // bypass to the head.
      applyStimulus(1'b1, 1'b1, 6'd17);
      checkOutput("emptypp_count", int'(count), 1);
      checkOutput("emptypp_tag", int'(dispatchTag), 17);
      checkOutput("emptypp_empty", int'(empty), 0);
      checkOutput("emptypp_err", int'(err), 0);

      // Pop while empty with no push.
      applyStimulus(1'b1, 1'b0, 6'd0);
      checkOutput("pop17_empty", int'(empty), 1);
      applyStimulus(1'b1, 1'b0, 6'd0);
      checkOutput("emptypop_count", int'(count), 0);
      checkOutput("emptypop_empty", int'(empty), 1);
      checkOutput("emptypop_err", int'(err), int'(ERR_EN));

      // Full list, push and pop together: the pop wins and the push is
      // dropped.
      doReset();
      checkOutput("fullpp_tag0", int'(dispatchTag), 0);
      applyStimulus(1'b1, 1'b1, 6'd3);
      checkOutput("fullpp_count", int'(count), 63);
      checkOutput("fullpp_tag", int'(dispatchTag), 1);
      checkOutput("fullpp_err", int'(err), int'(ERR_EN));

      // Drain 10 tags, then return 5, 9, 2. These must surface after 10..63.
      doReset();
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 6'd0);
      applyStimulus(1'b0, 1'b1, 6'd5);
      applyStimulus(1'b0, 1'b1, 6'd9);
      applyStimulus(1'b0, 1'b1, 6'd2);
      checkOutput("wrap_count", int'(count), 57);
      for (int i = 10; i < 64; i++) begin
         checkOutput("wrap_tag", int'(dispatchTag), i);
         applyStimulus(1'b1, 1'b0, 6'd0);
      end
      checkOutput("wrap_ret0", int'(dispatchTag), 5);
      applyStimulus(1'b1, 1'b0, 6'd0);
      checkOutput("wrap_ret1", int'(dispatchTag), 9);
      applyStimulus(1'b1, 1'b0, 6'd0);
      checkOutput("wrap_ret2", int'(dispatchTag), 2);
      applyStimulus(1'b1, 1'b0, 6'd0);
      checkOutput("wrap_empty", int'(empty), 1);

      // Assert reset mid-stream, between edges, with requests pending.
      doReset();
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 6'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 6'(40 + i));
      checkOutput("mid_count_pre", int'(count), 48);
      ren       = 1'b1;
      wen       = 1'b1;
      commitTag = 6'd7;
      #2 reset = 1'b1;
      #1;
      checkOutput("async_count", int'(count), 64);
      checkOutput("async_tag", int'(dispatchTag), 0);
      checkOutput("async_full", int'(full), 1);
      checkOutput("async_err", int'(err), 0);
      @(posedge clk);
      #1;
      checkOutput("inrst_count", int'(count), 64);
      checkOutput("inrst_tag", int'(dispatchTag), 0);
      ren = 1'b0;
      wen = 1'b0;
      #2 reset = 1'b0;
      @(posedge clk);
      #1;

      // Randomized traffic. The pop/push bias changes every 200 cycles, so
      // that the list spends time both near empty and near full.
      for (int blk = 0; blk < 15; blk++) begin
         case (blk % 5)
            0: begin pRen = 80; pWen = 20; end
            1: begin pRen = 20; pWen = 80; end
            2: begin pRen = 50; pWen = 50; end
            3: begin pRen = 95; pWen = 5;  end
            default: begin pRen = 5; pWen = 95; end
         endcase
         for (int c = 0; c < 200; c++) begin
            applyStimulus($urandom_range(99) < pRen, $urandom_range(99) < pWen,
                          6'($urandom));
         end
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
